// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//
// Memory-mapped interrupt controller for the d16 core. Each source line is
// rising-edge detected into a pending bit, gated by a software mask and
// priority-encoded (index 0 wins). One request at a time is presented to the
// core through an irq/ack handshake, and service ends with an EOI write.
// Source 0 is the timer expiry line.
//
// Register map (unused high bits read 0 and ignore writes):
//   addr 0 PENDING : read pending, write-1-to-clear
//   addr 1 MASK    : read/write, 1 = source enabled
//   addr 2 STATUS  : {in_service, 11'b0, active_vector}, read-only
//   addr 3 EOI     : any write ends service, reads 0
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   en         peripheral select from bus decode
//   wr_en      write strobe, effective only with en=1
//   addr       register select
//   data_in    write data
//   data_out   read data, combinational from addr
//   src_in     level event lines, bit 0 = timer expired
//   irq        interrupt request to the core
//   irq_vector index of the requested source, valid while irq=1
//   irq_ack    one-cycle acknowledge from the core
// -----------------------------------------------------------------------------
module irq_controller #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               wr_en,
  input  logic [1:0]         addr,
  input  logic [15:0]        data_in,
  output logic [15:0]        data_out,
  input  logic [NUM_SRC-1:0] src_in,
  output logic               irq,
  output logic [3:0]         irq_vector,
  input  logic               irq_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [3:0]         active_vector_reg, active_vector_next;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] mask_reg;
  logic [NUM_SRC-1:0] src_q;

  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] cand_bits;
  logic [NUM_SRC-1:0] sel_onehot;
  logic [NUM_SRC-1:0] w1c_clr;
  logic [3:0]         candidate;
  logic               req_valid;
  logic               ack_take;
  logic               wr_pending;
  logic               wr_mask;
  logic               wr_eoi;
  logic [15:0]        pending_ext;
  logic [15:0]        mask_ext;
  logic               unused_data;

  // Only the low NUM_SRC write bits reach the registers.
  assign unused_data = ^data_in;

  assign wr_pending = en & wr_en & (addr == 2'd0);
  assign wr_mask    = en & wr_en & (addr == 2'd1);
  assign wr_eoi     = en & wr_en & (addr == 2'd3);

  // src_q resets to all ones so lines already high at reset release
  // (timer counter sitting at zero) do not register a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '1;
    end else begin
      src_q <= src_in;
    end
  end

  assign edges     = src_in & ~src_q;
  assign cand_bits = pending_reg & mask_reg;

  // The request stays valid only while its pending bit is set and unmasked;
  // a W1C or mask-off while in REQ withdraws it immediately.
  assign req_valid = |(cand_bits & sel_onehot);
  assign ack_take  = (state_reg == REQ) & req_valid & irq_ack;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign sel_onehot[gi] = (active_vector_reg == 4'(gi));
      assign w1c_clr[gi]    = wr_pending & data_in[gi];
      // A new edge outranks both clear paths in the same cycle.
      assign pending_next[gi] = edges[gi] |
                                (pending_reg[gi] & ~w1c_clr[gi] &
                                 ~(ack_take & sel_onehot[gi]));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_reg <= '0;
    end else if (wr_mask) begin
      mask_reg <= data_in[NUM_SRC-1:0];
    end
  end

  // Lowest-index enabled pending source wins.
  always_comb begin
    candidate = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand_bits[i]) begin
        candidate = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      active_vector_reg <= '0;
    end else begin
      state_reg         <= state_next;
      active_vector_reg <= active_vector_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    active_vector_next = active_vector_reg;
    case (state_reg)
      IDLE: begin
        if (|cand_bits) begin
          active_vector_next = candidate;
          state_next         = REQ;
        end
      end
      REQ: begin
        if (!req_valid) begin
          state_next = IDLE;
        end else if (irq_ack) begin
          state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (wr_eoi) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output is decoded from the state register, so an asynchronous reset
  // drops irq without waiting for a clock.
  assign irq        = (state_reg == REQ) & req_valid;
  assign irq_vector = irq ? active_vector_reg : 4'd0;

  always_comb begin
    pending_ext                = '0;
    pending_ext[NUM_SRC-1:0]   = pending_reg;
    mask_ext                   = '0;
    mask_ext[NUM_SRC-1:0]      = mask_reg;
    data_out                   = '0;
    case (addr)
      2'd0:    data_out = pending_ext;
      2'd1:    data_out = mask_ext;
      2'd2:    data_out = {(state_reg == SERVICE), 11'b0, active_vector_reg};
      default: data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr_en;
  logic [1:0]  addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [7:0]  src_in;
  logic        irq;
  logic [3:0]  irq_vector;
  logic        irq_ack;

  int checks = 0;
  int errors = 0;

  irq_controller #(.NUM_SRC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_en      (wr_en),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .src_in     (src_in),
    .irq        (irq),
    .irq_vector (irq_vector),
    .irq_ack    (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
    en = 1'b1; wr_en = 1'b1; addr = a; data_in = d;
    tick();
    en = 1'b0; wr_en = 1'b0; data_in = '0;
  endtask

  task automatic reg_read(input string tag, input logic [1:0] a, input logic [15:0] exp);
    addr = a;
    #1;
    check(tag, data_out, exp);
    $display("read  %-14s addr=%0d data=%h exp=%h", tag, a, data_out, exp);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; addr = 2'd0; data_in = '0;
    src_in = 8'h01; irq_ack = 1'b0;

    // Reset state, timer line already high
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq", {15'b0, irq}, 16'h0000);
    check("rst_vec", {12'b0, irq_vector}, 16'h0000);
    reg_read("rst_pending", 2'd0, 16'h0000);
    reg_read("rst_status", 2'd2, 16'h0000);
    rst = 1'b0;

    // Held-high line after reset must not register an edge
    reg_write(2'd1, 16'h0001);
    tick(); tick();
    reg_read("hold_pending", 2'd0, 16'h0000);
    check("hold_irq", {15'b0, irq}, 16'h0000);
    src_in = 8'h00; tick();
    src_in = 8'h01; tick();
    reg_read("t0_pending", 2'd0, 16'h0001);
    check("t0_irq_early", {15'b0, irq}, 16'h0000);
    tick();
    check("t0_irq", {15'b0, irq}, 16'h0001);
    check("t0_vec", {12'b0, irq_vector}, 16'h0000);
    ack();
    check("t0_irq_ack", {15'b0, irq}, 16'h0000);
    reg_read("t0_status_svc", 2'd2, 16'h8000);
    reg_write(2'd3, 16'h0000);
    reg_read("t0_status_eoi", 2'd2, 16'h0000);

    // Single pulse on source 3
    reg_write(2'd1, 16'h00FF);
    reg_read("mask_rb", 2'd1, 16'h00FF);
    src_in = 8'h09; tick();
    src_in = 8'h01;
    reg_read("s3_pending", 2'd0, 16'h0008);
    tick();
    check("s3_irq", {15'b0, irq}, 16'h0001);
    check("s3_vec", {12'b0, irq_vector}, 16'h0003);
    ack();
    reg_read("s3_pend_ack", 2'd0, 16'h0000);
    reg_read("s3_status_svc", 2'd2, 16'h8003);
    check("s3_irq_svc", {15'b0, irq}, 16'h0000);
    reg_write(2'd3, 16'h0000);
    reg_read("s3_status_eoi", 2'd2, 16'h0003);

    // Sources 5 and 2 together: 2 first, then 5 after one idle cycle
    src_in = 8'h25; tick();
    src_in = 8'h01;
    reg_read("s25_pending", 2'd0, 16'h0024);
    tick();
    check("s25_vec_a", {12'b0, irq_vector}, 16'h0002);
    ack();
    reg_read("s25_pend_ack", 2'd0, 16'h0020);
    reg_write(2'd3, 16'h0000);
    check("s25_idle_gap", {15'b0, irq}, 16'h0000);
    tick();
    check("s25_irq_b", {15'b0, irq}, 16'h0001);
    check("s25_vec_b", {12'b0, irq_vector}, 16'h0005);
    ack();
    reg_write(2'd3, 16'h0000);

    // Masked source, later enabled
    reg_write(2'd1, 16'h0000);
    src_in = 8'h03; tick();
    src_in = 8'h01; tick();
    check("m1_irq_masked", {15'b0, irq}, 16'h0000);
    reg_read("m1_pending", 2'd0, 16'h0002);
    reg_write(2'd1, 16'h0002);
    check("m1_irq_one_edge", {15'b0, irq}, 16'h0000);
    tick();
    check("m1_irq", {15'b0, irq}, 16'h0001);
    check("m1_vec", {12'b0, irq_vector}, 16'h0001);
    ack();
    reg_write(2'd3, 16'h0000);

    // W1C racing a new edge on the requested bit: set wins
    reg_write(2'd1, 16'h00FF);
    src_in = 8'h11; tick();
    src_in = 8'h01; tick();
    check("s4_vec", {12'b0, irq_vector}, 16'h0004);
    src_in = 8'h11;
    reg_write(2'd0, 16'h0010);
    src_in = 8'h01;
    reg_read("s4_pend_race", 2'd0, 16'h0010);
    check("s4_irq_race", {15'b0, irq}, 16'h0001);
    // Plain W1C withdraws the request
    reg_write(2'd0, 16'h0010);
    check("s4_irq_withdrawn", {15'b0, irq}, 16'h0000);
    tick();
    reg_read("s4_status_idle", 2'd2, 16'h0004);

    // Asynchronous reset while in SERVICE with a pending bit
    src_in = 8'h41; tick();
    src_in = 8'h01; tick();
    check("s6_vec", {12'b0, irq_vector}, 16'h0006);
    ack();
    src_in = 8'h81; tick();
    src_in = 8'h01;
    reg_read("s6_status_svc", 2'd2, 16'h8006);
    reg_read("s6_pending7", 2'd0, 16'h0080);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_irq", {15'b0, irq}, 16'h0000);
    reg_read("arst_pending", 2'd0, 16'h0000);
    reg_read("arst_mask", 2'd1, 16'h0000);
    reg_read("arst_status", 2'd2, 16'h0000);
    tick();
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
